uart_iram_loader: RTL and testbench

- Boot-time program loader sitting directly upstream of the core's instruction RAM. Replaces the simulation-only hex preload with a path that works on silicon.
- Receives a framed program image on uart0_rx, assembles little-endian 32-bit words and writes them through a dedicated IRAM write port.
- Holds the core in reset until a frame passes its checksum, then releases it.
- Instantiated in sparrow_soc between the uart0_rx pad and the iram second port.

---
 rtl/uart_iram_loader_pkg.sv | 5 +
 rtl/uart_iram_loader_if.sv | 8 +
 rtl/uart_iram_loader_rx.sv | 82 ++++++++
 rtl/uart_iram_loader.sv | 162 ++++++++++++++++
 tb/tb_uart_iram_loader.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_iram_loader_pkg.sv
// Shared types and constants for the UART boot loader.
package loader_pkg;
  typedef enum logic [2:0] {IDLE, CNT_L, CNT_H, DATA, CSUM, DONE, ERR} ldr_state_t;
  localparam logic [7:0] LDR_MAGIC = 8'h5A;
endpackage

// File: rtl/uart_iram_loader_if.sv
// IRAM write port driven by the boot loader.
interface uart_iram_loader_if #(parameter int ADDR_W = 13);
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  modport master (output we, addr, wdata);
  modport slave  (input  we, addr, wdata);
endinterface

// File: rtl/uart_iram_loader_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, start-bit glitch reject, centre sampling.
module uart_rx_byte #(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_ferr_o
);
  localparam int CW   = $clog2(DIV);
  localparam int HALF = DIV / 2;
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

  logic [2:0]    sync_q;
  logic [1:0]    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          valid_q, valid_d, ferr_q, ferr_d;
  logic          rx_s, rx_p;

  // sync_q[1] is the synchronized line, sync_q[2] its previous value for edge detect
  assign rx_s = sync_q[1];
  assign rx_p = sync_q[2];

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (st_q)
      S_IDLE: if (rx_p && !rx_s) begin
        st_d  = S_START;
        cnt_d = '0;
      end
      S_START: if (cnt_q == CW'(HALF - 1)) begin
        cnt_d = '0;
        bit_d = '0;
        st_d  = rx_s ? S_IDLE : S_DATA;
      end else cnt_d = cnt_q + CW'(1);
      S_DATA: if (cnt_q == CW'(DIV - 1)) begin
        cnt_d = '0;
        sh_d  = {rx_s, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) st_d = S_STOP;
      end else cnt_d = cnt_q + CW'(1);
      default: if (cnt_q == CW'(DIV - 1)) begin
        st_d    = S_IDLE;
        valid_d = rx_s;
        ferr_d  = !rx_s;
      end else cnt_d = cnt_q + CW'(1);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 3'b111;
      st_q    <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], rx_i};
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data_o  = sh_q;
  assign rx_valid_o = valid_q;
  assign rx_ferr_o  = ferr_q;
endmodule

// File: rtl/uart_iram_loader.sv
// Boot loader: receives a framed image over UART, writes IRAM, releases core reset on good checksum.
module uart_iram_loader
  import loader_pkg::*;
#(
  parameter int DIV         = 434,
  parameter int ADDR_W      = 13,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 boot_sel,
  input  logic                 uart_rx,
  uart_iram_loader_if.master   iram,
  output logic                 core_rst_n,
  output logic                 load_done,
  output logic                 load_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (uart_rx),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ferr_o  (rx_ferr)
  );

  ldr_state_t        st_q, st_d;
  logic              sampled_q;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [15:0]       left_q, left_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [31:0]       word_q, word_d, wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        sum_q, sum_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              core_q, core_d, done_q, done_d, err_q, err_d;
  logic [15:0]       n_w;
  logic              active;

  assign n_w    = {rx_data, cnt_lo_q};
  assign active = (st_q == CNT_L) || (st_q == CNT_H) || (st_q == DATA) || (st_q == CSUM);

  always_comb begin
    st_d     = st_q;
    cnt_lo_d = cnt_lo_q;
    left_d   = left_q;
    bidx_d   = bidx_q;
    word_d   = word_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    sum_d    = sum_q;
    core_d   = core_q;
    done_d   = done_q;
    err_d    = err_q;
    tmo_d    = '0;
    if (!sampled_q) begin
      if (!boot_sel) st_d = DONE;
    end else begin
      case (st_q)
        IDLE: if (rx_valid && rx_data == LDR_MAGIC) begin
          st_d  = CNT_L;
          err_d = 1'b0;
          sum_d = '0;
        end
        CNT_L: if (rx_valid) begin
          cnt_lo_d = rx_data;
          st_d     = CNT_H;
        end
        CNT_H: if (rx_valid) begin
          if (n_w == 16'd0) st_d = CSUM;
          else if ({16'd0, n_w} > (32'd1 << ADDR_W)) st_d = ERR;
          else begin
            st_d   = DATA;
            addr_d = '0;
            bidx_d = '0;
            left_d = n_w;
          end
        end
        DATA: begin
          if (rx_valid) begin
            word_d = {rx_data, word_q[31:8]};
            sum_d  = sum_q + rx_data;
            bidx_d = bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
              we_d    = 1'b1;
              wdata_d = {rx_data, word_q[31:8]};
            end
          end
          // Address advances the cycle after each write; the final wrap is harmless once out of DATA
          if (we_q) begin
            addr_d = addr_q + ADDR_W'(1);
            left_d = left_q - 16'd1;
            if (left_q == 16'd1) st_d = CSUM;
          end
        end
        CSUM: if (rx_valid) st_d = (rx_data == sum_q) ? DONE : ERR;
        DONE: begin
          core_d = 1'b1;
          done_d = 1'b1;
        end
        default: begin
          err_d = 1'b1;
          st_d  = IDLE;
        end
      endcase
      if (active) begin
        if (rx_valid) tmo_d = '0;
        else if (tmo_q == TW'(TIMEOUT_CYC - 1)) st_d = ERR;
        else tmo_d = tmo_q + TW'(1);
      end
      if (rx_ferr && st_q != DONE) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      sampled_q <= 1'b0;
      cnt_lo_q  <= '0;
      left_q    <= '0;
      bidx_q    <= '0;
      word_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      sum_q     <= '0;
      tmo_q     <= '0;
      core_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      sampled_q <= 1'b1;
      cnt_lo_q  <= cnt_lo_d;
      left_q    <= left_d;
      bidx_q    <= bidx_d;
      word_q    <= word_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      sum_q     <= sum_d;
      tmo_q     <= tmo_d;
      core_q    <= core_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign iram.we    = we_q;
  assign iram.addr  = addr_q;
  assign iram.wdata = wdata_q;
  assign core_rst_n = core_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
endmodule

// File: tb/tb_uart_iram_loader.sv
// Directed bench for uart_iram_loader: bypass, good/bad frames, N=0, size limit, timeout, framing, glitch, reset.
module tb_uart_iram_loader;
  localparam int DIV = 8, AW = 4, TMO = 200;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0, rst_n = 1'b0, boot_sel = 1'b0, uart_rx = 1'b1;
  logic core_rst_n, load_done, load_err;
  int total = 0, fails = 0;
  int wr_n = 0, we_long = 0;
  logic we_prev = 1'b0;
  logic [31:0] wa[8], wd[8];
  bq_t fr;

  uart_iram_loader_if #(.ADDR_W(AW)) iram ();

  uart_iram_loader #(.DIV(DIV), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .boot_sel   (boot_sel),
    .uart_rx    (uart_rx),
    .iram       (iram),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  // Write monitor: logs every strobe and flags strobes wider than one cycle
  always @(negedge clk) begin
    if (iram.we === 1'b1) begin
      if (wr_n < 8) begin
        wa[wr_n] = 32'(iram.addr);
        wd[wr_n] = iram.wdata;
      end
      wr_n++;
      if (we_prev) we_long++;
    end
    we_prev = (iram.we === 1'b1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tx_byte(input logic [7:0] b, input logic stop_ok);
    uart_rx = 1'b0;
    cyc(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      cyc(DIV);
    end
    uart_rx = stop_ok;
    cyc(DIV);
    uart_rx = 1'b1;
    if (!stop_ok) cyc(DIV);
  endtask

  task automatic tx_seq(input bq_t q);
    foreach (q[i]) tx_byte(q[i], 1'b1);
  endtask

  task automatic do_reset(input logic sel);
    @(negedge clk);
    rst_n = 1'b0;
    boot_sel = sel;
    uart_rx = 1'b1;
    cyc(3);
    wr_n = 0;
    we_long = 0;
    rst_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    // Bypass boot
    boot_sel = 1'b0;
    cyc(2);
    chk("rst_we", iram.we, 0);
    chk("rst_addr", 32'(iram.addr), 0);
    chk("rst_wdata", iram.wdata, 0);
    chk("rst_core", core_rst_n, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    rst_n = 1'b1;
    cyc(1);
    chk("byp_early_core", core_rst_n, 0);
    cyc(1);
    chk("byp_core", core_rst_n, 1);
    chk("byp_done", load_done, 1);
    fr = '{8'h5A, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    tx_seq(fr);
    cyc(5);
    chk("byp_nowr", wr_n, 0);
    chk("byp_done_hold", load_done, 1);

    // Good two-word frame
    do_reset(1'b1);
    chk("ld_core_held", core_rst_n, 0);
    fr = '{8'h5A, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
    tx_seq(fr);
    cyc(4);
    chk("good_wr_n", wr_n, 2);
    chk("good_a0", wa[0], 0);
    chk("good_d0", wd[0], 32'h0000_0013);
    chk("good_a1", wa[1], 1);
    chk("good_d1", wd[1], 32'h0000_006F);
    chk("good_we_1cyc", we_long, 0);
    chk("good_done", load_done, 1);
    chk("good_core", core_rst_n, 1);
    chk("good_err", load_err, 0);

    // Bad checksum, then resend
    do_reset(1'b1);
    fr = '{8'h5A, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h83};
    tx_seq(fr);
    cyc(4);
    chk("bad_err", load_err, 1);
    chk("bad_done", load_done, 0);
    chk("bad_core", core_rst_n, 0);
    tx_byte(8'h5A, 1'b1);
    cyc(2);
    chk("resend_err_clr", load_err, 0);
    fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
    tx_seq(fr);
    cyc(4);
    chk("resend_wr_n", wr_n, 4);
    chk("resend_a2", wa[2], 0);
    chk("resend_d3", wd[3], 32'h0000_006F);
    chk("resend_done", load_done, 1);
    chk("resend_core", core_rst_n, 1);

    // Garbage then N=0 frame
    do_reset(1'b1);
    fr = '{8'h11, 8'hFF};
    tx_seq(fr);
    cyc(2);
    chk("garb_err", load_err, 0);
    chk("garb_done", load_done, 0);
    fr = '{8'h5A, 8'h00, 8'h00, 8'h00};
    tx_seq(fr);
    cyc(4);
    chk("n0_done", load_done, 1);
    chk("n0_nowr", wr_n, 0);

    // Size limit: N = 2**AW accepted, N = 2**AW + 1 rejected
    do_reset(1'b1);
    fr = '{8'h5A, 8'h10, 8'h00};
    tx_seq(fr);
    cyc(4);
    chk("nmax_ok", load_err, 0);
    do_reset(1'b1);
    fr = '{8'h5A, 8'h11, 8'h00};
    tx_seq(fr);
    cyc(4);
    chk("nbig_err", load_err, 1);
    chk("nbig_core", core_rst_n, 0);

    // Inter-byte timeout after 3 data bytes
    do_reset(1'b1);
    fr = '{8'h5A, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    tx_seq(fr);
    cyc(190);
    chk("tmo_early", load_err, 0);
    cyc(20);
    chk("tmo_err", load_err, 1);
    chk("tmo_nowr", wr_n, 0);

    // Framing error drops the byte
    do_reset(1'b1);
    tx_byte(8'h5A, 1'b0);
    cyc(2);
    chk("ferr_err", load_err, 1);
    fr = '{8'h00, 8'h00, 8'h00};
    tx_seq(fr);
    cyc(4);
    chk("ferr_dropped", load_done, 0);

    // Short low glitch must not produce a byte
    do_reset(1'b1);
    fr = '{8'h5A, 8'h00, 8'h00};
    tx_seq(fr);
    uart_rx = 1'b0;
    cyc(2);
    uart_rx = 1'b1;
    cyc(90);
    chk("glitch_err", load_err, 0);
    tx_byte(8'h00, 1'b1);
    cyc(4);
    chk("glitch_done", load_done, 1);

    // Asynchronous reset during DATA
    do_reset(1'b1);
    fr = '{8'h5A, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    tx_seq(fr);
    cyc(3);
    chk("mid_addr", 32'(iram.addr), 1);
    chk("mid_wdata", iram.wdata, 32'h0000_0013);
    uart_rx = 1'b0;
    cyc(10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", iram.we, 0);
    chk("arst_addr", 32'(iram.addr), 0);
    chk("arst_wdata", iram.wdata, 0);
    chk("arst_core", core_rst_n, 0);
    chk("arst_done", load_done, 0);
    chk("arst_err", load_err, 0);
    @(negedge clk);
    uart_rx = 1'b1;
    rst_n = 1'b1;
    cyc(2);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
